// File: rtl/tag_shiftreg_kill_if.sv
// Datapath and lookup signals of tag_shiftreg_kill, bundled as one port.
// The design side uses the slave modport. The driving side uses the master modport.
interface tag_shiftreg_kill_if #(
  parameter int TAG_SIZE      = 5,
  parameter int DATA_SIZE     = 8,
  parameter int NUM_STAGES    = 3,
  parameter int NUM_TESTPORTS = 3
);
  localparam int COUNT_W = $clog2(NUM_STAGES + 1);

  logic                                      shift;
  logic [TAG_SIZE-1:0]                       tag;
  logic                                      tag_valid;
  logic [DATA_SIZE-1:0]                      datain;
  logic                                      flush;
  logic                                      kill;
  logic [TAG_SIZE-1:0]                       kill_tag;
  logic [NUM_TESTPORTS-1:0][TAG_SIZE-1:0]    test;
  logic [NUM_TESTPORTS-1:0]                  found;
  logic [NUM_TESTPORTS-1:0][NUM_STAGES-1:0]  index;
  logic [NUM_TESTPORTS-1:0][DATA_SIZE-1:0]   dataout;
  logic [NUM_TESTPORTS-1:0]                  hit_input;
  logic                                      out_valid;
  logic [TAG_SIZE-1:0]                       out_tag;
  logic [DATA_SIZE-1:0]                      out_data;
  logic [COUNT_W-1:0]                        count;

  modport master (
    output shift, tag, tag_valid, datain, flush, kill, kill_tag, test,
    input  found, index, dataout, hit_input, out_valid, out_tag, out_data, count
  );

  modport slave (
    input  shift, tag, tag_valid, datain, flush, kill, kill_tag, test,
    output found, index, dataout, hit_input, out_valid, out_tag, out_data, count
  );
endinterface

// File: rtl/tag_shiftreg_kill.sv
// In-flight tag shift register with flush and kill-by-tag.
// Provides multi-port youngest-match lookup, an optional input bypass, a retire port and an occupancy count.
module tag_shiftreg_kill #(
  parameter int TAG_SIZE      = 5,
  parameter int DATA_SIZE     = 8,
  parameter int NUM_STAGES    = 3,
  parameter int NUM_TESTPORTS = 3,
  parameter int BYPASS        = 0
) (
  input logic                clk,
  input logic                reset,
  tag_shiftreg_kill_if.slave bus
);
  localparam int COUNT_W = $clog2(NUM_STAGES + 1);

  logic [NUM_STAGES-1:0]                 valid_q, valid_d;
  logic [NUM_STAGES-1:0][TAG_SIZE-1:0]   tag_q, tag_d;
  logic [NUM_STAGES-1:0][DATA_SIZE-1:0]  data_q, data_d;
  logic                                  out_valid_q, out_valid_d;
  logic [TAG_SIZE-1:0]                   out_tag_q, out_tag_d;
  logic [DATA_SIZE-1:0]                  out_data_q, out_data_d;
  logic [COUNT_W-1:0]                    count_q, count_d;

  logic                                      bypass_ok;
  logic [NUM_TESTPORTS-1:0]                  found_c;
  logic [NUM_TESTPORTS-1:0][NUM_STAGES-1:0]  index_c;
  logic [NUM_TESTPORTS-1:0][DATA_SIZE-1:0]   dataout_c;
  logic [NUM_TESTPORTS-1:0]                  hit_c;

  // Kill and flush act on the post-shift contents; the retiring entry escapes kill.
  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    out_valid_d = 1'b0;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;
    count_d     = '0;
    if (bus.shift) begin
      out_valid_d = valid_q[NUM_STAGES-1];
      out_tag_d   = tag_q[NUM_STAGES-1];
      out_data_d  = data_q[NUM_STAGES-1];
      for (int i = 1; i < NUM_STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        tag_d[i]   = tag_q[i-1];
        data_d[i]  = data_q[i-1];
      end
      valid_d[0] = bus.tag_valid;
      tag_d[0]   = bus.tag;
      data_d[0]  = bus.datain;
    end
    if (bus.kill) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (tag_d[i] == bus.kill_tag) valid_d[i] = 1'b0;
      end
    end
    if (bus.flush) begin
      valid_d     = '0;
      out_valid_d = 1'b0;
    end
    for (int i = 0; i < NUM_STAGES; i++) begin
      count_d = count_d + COUNT_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
      count_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
    end
  end

  // The oldest-to-youngest scan makes the youngest match win the data select.
  // A bypassed input is younger than every stage.
  always_comb begin
    bypass_ok = bus.shift && bus.tag_valid && !bus.flush &&
                !(bus.kill && (bus.kill_tag == bus.tag));
    for (int p = 0; p < NUM_TESTPORTS; p++) begin
      index_c[p]   = '0;
      dataout_c[p] = '0;
      hit_c[p]     = 1'b0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
        if (valid_q[i] && (tag_q[i] == bus.test[p])) begin
          index_c[p][i] = 1'b1;
          dataout_c[p]  = data_q[i];
        end
      end
      if ((BYPASS != 0) && bypass_ok && (bus.tag == bus.test[p])) begin
        hit_c[p]     = 1'b1;
        dataout_c[p] = bus.datain;
      end
      found_c[p] = (|index_c[p]) || hit_c[p];
    end
  end

  assign bus.found     = found_c;
  assign bus.index     = index_c;
  assign bus.dataout   = dataout_c;
  assign bus.hit_input = hit_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_data  = out_data_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_tag_shiftreg_kill.sv
// Bench for tag_shiftreg_kill that drives one BYPASS=0 and one BYPASS=1 instance with the same stimulus.
// Both instances are checked every cycle against a queue-based reference model.
module tb_tag_shiftreg_kill;
  localparam int TS = 5;
  localparam int DS = 8;
  localparam int NS = 3;
  localparam int NP = 3;

  typedef struct {
    logic          v;
    logic [TS-1:0] tag;
    logic [DS-1:0] data;
  } ent_t;

  logic clk;
  logic reset;
  logic shift;
  logic tag_valid;
  logic flush;
  logic kill;
  logic [TS-1:0] tag;
  logic [TS-1:0] kill_tag;
  logic [DS-1:0] datain;
  logic [NP-1:0][TS-1:0] test;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  ent_t          mq[$];
  logic          mOutV;
  logic [TS-1:0] mOutTag;
  logic [DS-1:0] mOutData;

  tag_shiftreg_kill_if #(.TAG_SIZE(TS), .DATA_SIZE(DS), .NUM_STAGES(NS), .NUM_TESTPORTS(NP)) bus0 ();
  tag_shiftreg_kill_if #(.TAG_SIZE(TS), .DATA_SIZE(DS), .NUM_STAGES(NS), .NUM_TESTPORTS(NP)) bus1 ();

  assign bus0.shift = shift;       assign bus1.shift = shift;
  assign bus0.tag = tag;           assign bus1.tag = tag;
  assign bus0.tag_valid = tag_valid; assign bus1.tag_valid = tag_valid;
  assign bus0.datain = datain;     assign bus1.datain = datain;
  assign bus0.flush = flush;       assign bus1.flush = flush;
  assign bus0.kill = kill;         assign bus1.kill = kill;
  assign bus0.kill_tag = kill_tag; assign bus1.kill_tag = kill_tag;
  assign bus0.test = test;         assign bus1.test = test;

  tag_shiftreg_kill #(.TAG_SIZE(TS), .DATA_SIZE(DS), .NUM_STAGES(NS), .NUM_TESTPORTS(NP), .BYPASS(0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  tag_shiftreg_kill #(.TAG_SIZE(TS), .DATA_SIZE(DS), .NUM_STAGES(NS), .NUM_TESTPORTS(NP), .BYPASS(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic modelReset();
    mq.delete();
    for (int i = 0; i < NS; i++) mq.push_back('{v: 1'b0, tag: '0, data: '0});
    mOutV    = 1'b0;
    mOutTag  = '0;
    mOutData = '0;
  endtask

  // Entries enter at the front of the queue and retire off the back.
  task automatic modelStep();
    ent_t retired;
    if (reset) begin
      modelReset();
      return;
    end
    if (shift) begin
      retired = mq.pop_back();
      mq.push_front('{v: tag_valid, tag: tag, data: datain});
      mOutV    = retired.v && !flush;
      mOutTag  = retired.tag;
      mOutData = retired.data;
    end else begin
      mOutV = 1'b0;
    end
    foreach (mq[i]) begin
      if (kill && (mq[i].tag == kill_tag)) mq[i].v = 1'b0;
      if (flush) mq[i].v = 1'b0;
    end
  endtask

  function automatic void expLookup(input int byp, input int p, output logic f,
                                    output logic [NS-1:0] idx, output logic [DS-1:0] d,
                                    output logic h);
    f = 1'b0; idx = '0; d = '0; h = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (mq[i].v && (mq[i].tag == test[p])) begin
        idx[i] = 1'b1;
        if (!f) d = mq[i].data;
        f = 1'b1;
      end
    end
    if ((byp != 0) && shift && tag_valid && !flush && (tag == test[p]) &&
        !(kill && (kill_tag == tag))) begin
      f = 1'b1; h = 1'b1; d = datain;
    end
  endfunction

  task automatic checkOutput();
    logic [NP-1:0]         fA[2];
    logic [NP-1:0]         hA[2];
    logic [NP-1:0][NS-1:0] iA[2];
    logic [NP-1:0][DS-1:0] dA[2];
    logic                  ovA[2];
    logic [TS-1:0]         otA[2];
    logic [DS-1:0]         odA[2];
    logic [1:0]            cA[2];
    logic                  ef;
    logic                  eh;
    logic [NS-1:0]         ei;
    logic [DS-1:0]         ed;
    int                    ecount;
    fA[0] = bus0.found;     fA[1] = bus1.found;
    hA[0] = bus0.hit_input; hA[1] = bus1.hit_input;
    iA[0] = bus0.index;     iA[1] = bus1.index;
    dA[0] = bus0.dataout;   dA[1] = bus1.dataout;
    ovA[0] = bus0.out_valid; ovA[1] = bus1.out_valid;
    otA[0] = bus0.out_tag;   otA[1] = bus1.out_tag;
    odA[0] = bus0.out_data;  odA[1] = bus1.out_data;
    cA[0] = bus0.count;      cA[1] = bus1.count;
    ecount = 0;
    foreach (mq[i]) if (mq[i].v) ecount++;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        expLookup(d, p, ef, ei, ed, eh);
        check($sformatf("dut%0d_found_p%0d", d, p), 32'(fA[d][p]), 32'(ef));
        check($sformatf("dut%0d_index_p%0d", d, p), 32'(iA[d][p]), 32'(ei));
        check($sformatf("dut%0d_dataout_p%0d", d, p), 32'(dA[d][p]), 32'(ed));
        check($sformatf("dut%0d_hit_p%0d", d, p), 32'(hA[d][p]), 32'(eh));
      end
      check($sformatf("dut%0d_out_valid", d), 32'(ovA[d]), 32'(mOutV));
      check($sformatf("dut%0d_count", d), 32'(cA[d]), 32'(ecount));
      if (mOutV) begin
        check($sformatf("dut%0d_out_tag", d), 32'(otA[d]), 32'(mOutTag));
        check($sformatf("dut%0d_out_data", d), 32'(odA[d]), 32'(mOutData));
      end
    end
  endtask

  task automatic applyStimulus(input logic sh, input logic tv, input logic [TS-1:0] tg,
                               input logic [DS-1:0] d, input logic fl, input logic kl,
                               input logic [TS-1:0] kt);
    shift = sh; tag_valid = tv; tag = tg; datain = d;
    flush = fl; kill = kl; kill_tag = kt;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic tick();
    #1;
    checkOutput();
    modelStep();
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    test = '0;
    idle();
    modelReset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_count", 32'(bus0.count), 32'd0);
    check("rst_out_valid", 32'(bus1.out_valid), 32'd0);

    // Reset in the middle of a fill
    applyStimulus(1'b1, 1'b1, 5'd3, 8'h11, 1'b0, 1'b0, '0); tick();
    applyStimulus(1'b1, 1'b1, 5'd7, 8'h22, 1'b0, 1'b0, '0); tick();
    reset = 1'b1; idle(); tick();
    reset = 1'b0;
    test[0] = 5'd3; test[1] = 5'd7; test[2] = 5'd0;
    #1;
    check("midrst_count", 32'(bus0.count), 32'd0);
    check("midrst_found", 32'(bus0.found), 32'd0);
    check("midrst_out_valid", 32'(bus0.out_valid), 32'd0);

    // Fill then retire the first entry
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b1, 5'(k), 8'(8'hA0 + k), 1'b0, 1'b0, '0);
      tick();
    end
    idle();
    #1;
    check("fill_out_valid", 32'(bus0.out_valid), 32'd1);
    check("fill_out_tag", 32'(bus0.out_tag), 32'd1);
    check("fill_out_data", 32'(bus0.out_data), 32'hA1);
    check("fill_count", 32'(bus0.count), 32'd3);
    tick();
    #1;
    check("fill_pulse_end", 32'(bus0.out_valid), 32'd0);

    // The youngest match selects the data
    applyStimulus(1'b1, 1'b1, 5'd5, 8'h30, 1'b0, 1'b0, '0); tick();
    applyStimulus(1'b1, 1'b1, 5'd9, 8'h20, 1'b0, 1'b0, '0); tick();
    applyStimulus(1'b1, 1'b1, 5'd5, 8'h10, 1'b0, 1'b0, '0); tick();
    idle();
    test[0] = 5'd5; test[1] = 5'd6; test[2] = 5'd9;
    #1;
    check("young_found0", 32'(bus0.found[0]), 32'd1);
    check("young_index0", 32'(bus0.index[0]), 32'b101);
    check("young_data0", 32'(bus0.dataout[0]), 32'h10);
    check("young_found1", 32'(bus0.found[1]), 32'd0);
    check("young_data1", 32'(bus0.dataout[1]), 32'd0);
    tick();

    // Kill applied together with a shift
    applyStimulus(1'b1, 1'b1, 5'd2, 8'h61, 1'b0, 1'b0, '0); tick();
    applyStimulus(1'b1, 1'b1, 5'd7, 8'h62, 1'b0, 1'b0, '0); tick();
    applyStimulus(1'b1, 1'b1, 5'd2, 8'h63, 1'b0, 1'b0, '0); tick();
    applyStimulus(1'b1, 1'b1, 5'd2, 8'h44, 1'b0, 1'b1, 5'd2); tick();
    idle();
    test[0] = 5'd2; test[1] = 5'd7; test[2] = 5'd0;
    #1;
    check("kill_count", 32'(bus0.count), 32'd1);
    check("kill_out_valid", 32'(bus0.out_valid), 32'd1);
    check("kill_out_tag", 32'(bus0.out_tag), 32'd2);
    check("kill_out_data", 32'(bus0.out_data), 32'h61);
    check("kill_found0", 32'(bus0.found[0]), 32'd0);
    check("kill_index1", 32'(bus0.index[1]), 32'b100);
    tick();

    // Flush takes priority over both shift and kill
    applyStimulus(1'b1, 1'b1, 5'd1, 8'h71, 1'b0, 1'b0, '0); tick();
    applyStimulus(1'b1, 1'b1, 5'd2, 8'h72, 1'b0, 1'b0, '0); tick();
    applyStimulus(1'b1, 1'b1, 5'd3, 8'h73, 1'b0, 1'b0, '0); tick();
    applyStimulus(1'b1, 1'b1, 5'd4, 8'h74, 1'b1, 1'b1, 5'd1); tick();
    idle();
    test[0] = 5'd4; test[1] = 5'd1; test[2] = 5'd2;
    #1;
    check("flush_count", 32'(bus0.count), 32'd0);
    check("flush_out_valid", 32'(bus0.out_valid), 32'd0);
    check("flush_found_d0", 32'(bus0.found), 32'd0);
    check("flush_found_d1", 32'(bus1.found), 32'd0);
    tick();

    // Input bypass on an empty register
    test[0] = 5'd0; test[1] = 5'd0; test[2] = 5'd6;
    applyStimulus(1'b1, 1'b1, 5'd6, 8'h55, 1'b0, 1'b0, '0);
    #1;
    check("byp_found_d1", 32'(bus1.found[2]), 32'd1);
    check("byp_hit_d1", 32'(bus1.hit_input[2]), 32'd1);
    check("byp_data_d1", 32'(bus1.dataout[2]), 32'h55);
    check("byp_index_d1", 32'(bus1.index[2]), 32'd0);
    check("byp_found_d0", 32'(bus0.found[2]), 32'd0);
    check("byp_hit_d0", 32'(bus0.hit_input[2]), 32'd0);
    tick();
    // A matching kill suppresses the bypass. Stage 0 still matches.
    applyStimulus(1'b1, 1'b1, 5'd6, 8'h56, 1'b0, 1'b1, 5'd6);
    #1;
    check("bypkill_hit_d1", 32'(bus1.hit_input[2]), 32'd0);
    check("bypkill_data_d1", 32'(bus1.dataout[2]), 32'h55);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd6, 8'h57, 1'b0, 1'b0, '0); tick();
    // The input is younger than a matching stage 0.
    applyStimulus(1'b1, 1'b1, 5'd6, 8'h58, 1'b0, 1'b0, '0);
    #1;
    check("bypyoung_data_d1", 32'(bus1.dataout[2]), 32'h58);
    check("bypyoung_index_d1", 32'(bus1.index[2]), 32'b001);
    check("bypyoung_data_d0", 32'(bus0.dataout[2]), 32'h57);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 5'd6); tick();
    idle();
    #1;
    check("killhold_count", 32'(bus0.count), 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd6, 8'h59, 1'b1, 1'b0, '0);
    #1;
    check("bypflush_hit_d1", 32'(bus1.hit_input[2]), 32'd0);
    tick();
    idle();
    tick();
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/tag_shiftreg_kill.md
Name: tag_shiftreg_kill

Overview:
- Parametrised successor to the tag shift register used for in-flight register-tag tracking (hazard detection, forwarding select) in the pipeline.
- Holds NUM_STAGES entries {valid, tag, data} that advance on shift.
- Zero-latency multi-port tag lookup with youngest-match data select.
- Adds over the previous generation: flush, kill-by-tag, an optional input bypass, a retire (shift-out) port and an occupancy count.

Parameters:
TAG_SIZE, 5, bits per tag (>=1)
DATA_SIZE, 8, bits of data per entry (>=1)
NUM_STAGES, 3, register stages (>=1); stage 0 youngest, NUM_STAGES-1 oldest
NUM_TESTPORTS, 3, simultaneous lookup ports (>=1)
BYPASS, 0, 1 = lookups also match the entry being shifted in this cycle

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high
shift  input  1  advance register by one stage
tag  input  TAG_SIZE  tag entering stage 0 on shift
tag_valid  input  1  valid bit entering stage 0 on shift
datain  input  DATA_SIZE  data entering stage 0 on shift
flush  input  1  invalidate all entries and the incoming entry
kill  input  1  invalidate entries whose tag equals kill_tag
kill_tag  input  TAG_SIZE  tag to kill
test  input  [NUM_TESTPORTS][TAG_SIZE]  lookup tags
found  output  [NUM_TESTPORTS]  any valid match on port p
index  output  [NUM_TESTPORTS][NUM_STAGES]  per-stage valid-match vector (multi-hot)
dataout  output  [NUM_TESTPORTS][DATA_SIZE]  data of youngest match, 0 if none
hit_input  output  [NUM_TESTPORTS]  match came from bypassed input (BYPASS=1 only, else 0)
out_valid  output  1  registered: valid of entry shifted out of oldest stage
out_tag  output  TAG_SIZE  registered: its tag
out_data  output  DATA_SIZE  registered: its data
count  output  $clog2(NUM_STAGES+1)  registered number of valid stages

Behaviour:
- Reset (clk edge with reset=1): all stage valid bits 0, tag/data 0, out_valid/out_tag/out_data 0, count 0. Reset overrides shift/flush/kill.
- Shift: stage0 <= {tag_valid,tag,datain}; stage i <= stage i-1. Oldest stage moves to out_* registers one cycle after the edge; out_valid is a 1-cycle pulse per shift, forced 0 when there is no shift or on flush.
- No shift: stages hold; out_valid <= 0.
- Kill: applied to next-state contents (post-shift), including the incoming entry; every entry with valid=1 and tag==kill_tag gets valid <= 0; tag and data are kept. The shifted-out entry is not killed (retire wins).
- Flush: all next-state valid bits 0, incoming entry dropped, out_valid <= 0. Flush dominates shift and kill.
- count: registered popcount of next-state valid bits; always equals the number of valid stages visible in the following cycle.
- Lookup (combinational, same cycle, from current stage contents):
  - index[p][i] = valid_i && tag_i==test[p].
  - found[p] = OR of index[p].
  - dataout[p] = data of the lowest i set in index[p] (youngest); 0 if none.
- BYPASS=1: if shift && tag_valid && !flush && tag==test[p] && !(kill && kill_tag==tag), the input counts as younger than stage 0.
  - found[p]=1, dataout[p]=datain, hit_input[p]=1.
  - index[p] is unaffected.
- Kill/flush do not affect the current-cycle lookup (they take effect from the next cycle).
- Duplicate tags in several stages are legal; index is multi-hot.
- NUM_STAGES=1: stage 0 is both youngest and oldest.

Test Plan:
- Reset mid-fill: shift tags 3,7 (data 0x11,0x22), assert reset -> next cycle count=0, found=0 on all ports, out_valid=0.
- Fill/retire: NUM_STAGES=3, shift tags 1,2,3,4 with data 0xA1..0xA4 -> after the 4th edge stages hold {4,3,2}; out_valid=1, out_tag=1, out_data=0xA1 for exactly one cycle; count=3.
- Youngest select: stages {5,9,5} with data {0x10,0x20,0x30}, test[0]=5 -> found[0]=1, index[0]=3'b101, dataout[0]=0x10; test[1]=6 -> found[1]=0, dataout[1]=0.
- Kill with shift: stages {2,7,2}, shift tag 2 with kill=1, kill_tag=2 -> next cycle stages {2(inv),2(inv),7}, count=1, out_tag=2 with out_valid=1.
- Flush priority: shift+kill+flush asserted together on a full register -> next cycle count=0, out_valid=0, all found=0.
- Bypass: BYPASS=1, empty register, shift tag 6 with data 0x55, test[2]=6 in the same cycle -> found[2]=1, hit_input[2]=1, dataout[2]=0x55, index[2]=0; with BYPASS=0 -> found[2]=0.
